inst_buffer: RTL and testbench

Instruction buffer between the IF stage and the dual-issue ID stage. IF issues one aligned 64-bit fetch (two instructions) per cycle and sends a request descriptor on `if_to_ib_bus`. This block tracks that request across the one-cycle synchronous SRAM read, drops stale or unaligned words, and enqueues up to two {pc, inst} entries per cycle. It presents the two oldest entries to ID, pops what ID consumes, and raises a stall request before overflow.

---
 rtl/inst_buffer_pkg.sv | 33 +++
 rtl/inst_buffer_ram.sv | 38 +++
 rtl/inst_buffer.sv | 133 +++++++++++++
 tb/tb_inst_buffer.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_buffer_pkg.sv
// Shared types and constants for the instruction buffer between IF and the
// dual-issue ID stage.
//   if_req_t   : field layout of the 66-bit IF -> IB request descriptor
//   ib_entry_t : one buffered instruction, {pc, inst}
package inst_buffer_pkg;

  localparam int IF_TO_IB_WD    = 66;
  localparam int IB_TO_ID_WD    = 130;  // two valid bits, two pcs, two insts
  localparam int IF_DISCARD_BIT = 65;
  localparam int IF_CE_BIT      = 64;
  localparam int IF_TARGET_LSB  = 32;
  localparam int IF_ALIGNED_LSB = 0;

  typedef struct packed {
    logic        discard;
    logic        ce;
    logic [31:0] pc_target;
    logic [31:0] pc_aligned;
  } if_req_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ib_entry_t;

  function automatic ib_entry_t make_entry(input logic [31:0] pc, input logic [31:0] inst);
    ib_entry_t e;
    e.pc   = pc;
    e.inst = inst;
    return e;
  endfunction

endpackage

// File: rtl/inst_buffer_ram.sv
// Entry storage for the instruction buffer: DEPTH x {pc, inst} register array.
// Two write ports (tail, tail+1) and two combinational read ports (head,
// head+1). Data is not reset; validity is tracked by the owner's count.
//   clk                 : clock
//   we0_i/waddr0_i/wdata0_i : write port 0
//   we1_i/waddr1_i/wdata1_i : write port 1 (never the same address as port 0)
//   raddr0_i/rdata0_o   : read port 0
//   raddr1_i/rdata1_o   : read port 1
module inst_buffer_ram
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic             clk,
  input  logic             we0_i,
  input  logic [PTR_W-1:0] waddr0_i,
  input  ib_entry_t        wdata0_i,
  input  logic             we1_i,
  input  logic [PTR_W-1:0] waddr1_i,
  input  ib_entry_t        wdata1_i,
  input  logic [PTR_W-1:0] raddr0_i,
  output ib_entry_t        rdata0_o,
  input  logic [PTR_W-1:0] raddr1_i,
  output ib_entry_t        rdata1_o
);

  ib_entry_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we0_i) mem_q[waddr0_i] <= wdata0_i;
    if (we1_i) mem_q[waddr1_i] <= wdata1_i;
  end

  assign rdata0_o = mem_q[raddr0_i];
  assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_buffer.sv
// Instruction buffer between IF and the dual-issue ID stage.
// Tracks the one-deep fetch request across the synchronous SRAM read, drops
// killed requests and the lower word of an odd-word target, enqueues up to two
// {pc, inst} entries per cycle and presents the two oldest entries to ID.
//   clk, rst            : clock, synchronous active-high reset
//   flush               : empties buffer and in-flight request, ignores id_pop
//   if_to_ib_bus        : {discard, ce, pc_target, pc_aligned}
//   inst_sram_rdata     : {word at pc_aligned+4, word at pc_aligned}
//   id_pop              : entries consumed by ID this cycle (0..2)
//   inst0_* / inst1_*   : head / head+1 entry (pc and inst are 0 when invalid)
//   stallreq_ib         : asks control to stall IF when fewer than 4 slots remain
//
// Handshake: an entry is offered while instN_valid is high; ID consumes it by
// counting it in id_pop in that cycle. id_pop never exceeds the valid count,
// and IF keeps pushes within capacity by honouring stallreq_ib.
module inst_buffer
  import inst_buffer_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic [IF_TO_IB_WD-1:0] if_to_ib_bus,
  input  logic [63:0]            inst_sram_rdata,
  input  logic [1:0]             id_pop,
  output logic                   inst0_valid,
  output logic                   inst1_valid,
  output logic [31:0]            inst0_pc,
  output logic [31:0]            inst1_pc,
  output logic [31:0]            inst0,
  output logic [31:0]            inst1,
  output logic                   stallreq_ib
);

  localparam int CNT_W = PTR_W + 1;

  if_req_t req_in;
  assign req_in = if_req_t'(if_to_ib_bus);

  logic             req_v_q, req_v_d;
  logic [31:0]      req_pc_q, req_base_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [1:0]       push_n, pop_n;

  ib_entry_t wdata0, wdata1, rdata0, rdata1;
  logic      we0, we1;

  always_comb begin
    // An odd-word target keeps only the upper word of the fetched pair.
    push_n = 2'd0;
    if (req_v_q && !flush) push_n = req_pc_q[2] ? 2'd1 : 2'd2;
    pop_n   = flush ? 2'd0 : id_pop;
    req_v_d = req_in.ce & ~req_in.discard & ~flush;
    if (flush) begin
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end else begin
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_v_q    <= 1'b0;
      req_pc_q   <= '0;
      req_base_q <= '0;
      count_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
    end else begin
      req_v_q    <= req_v_d;
      req_pc_q   <= req_in.pc_target;
      req_base_q <= req_in.pc_aligned;
      count_q    <= count_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
    end
  end

  always_comb begin
    we0    = (push_n != 2'd0) && !rst;
    we1    = (push_n == 2'd2) && !rst;
    wdata0 = (push_n == 2'd2) ? make_entry(req_base_q, inst_sram_rdata[31:0])
                              : make_entry(req_base_q + 32'd4, inst_sram_rdata[63:32]);
    wdata1 = make_entry(req_base_q + 32'd4, inst_sram_rdata[63:32]);
  end

  inst_buffer_ram #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk      (clk),
    .we0_i    (we0),
    .waddr0_i (tail_q),
    .wdata0_i (wdata0),
    .we1_i    (we1),
    .waddr1_i (tail_q + PTR_W'(1)),
    .wdata1_i (wdata1),
    .raddr0_i (head_q),
    .rdata0_o (rdata0),
    .raddr1_i (head_q + PTR_W'(1)),
    .rdata1_o (rdata1)
  );

  // Outputs are forced to zero when invalid so unreset storage never leaks.
  always_comb begin
    inst0_valid = (count_q != '0);
    inst1_valid = (count_q >= CNT_W'(2));
    inst0_pc    = inst0_valid ? rdata0.pc   : 32'd0;
    inst0       = inst0_valid ? rdata0.inst : 32'd0;
    inst1_pc    = inst1_valid ? rdata1.pc   : 32'd0;
    inst1       = inst1_valid ? rdata1.inst : 32'd0;
    // Four free slots cover the response already in flight plus one more fetch.
    stallreq_ib = (CNT_W'(DEPTH) - count_q) < CNT_W'(4);
  end

  // Occupancy after this edge; an extra bit makes a pop underflow wrap large.
  logic [CNT_W:0] occ_next;
  assign occ_next = {1'b0, count_q} + (CNT_W+1)'(push_n) - (CNT_W+1)'(pop_n);

  a_no_overflow: assert property (@(posedge clk) disable iff (rst || flush)
    occ_next <= (CNT_W+1)'(DEPTH));

  a_target_in_pair: assert property (@(posedge clk) disable iff (rst || flush)
    req_v_q |-> (req_pc_q[31:3] == req_base_q[31:3]));

endmodule

// File: tb/tb_inst_buffer.sv
module tb_inst_buffer;

  logic        clk;
  logic        rst;
  logic        flush;
  logic [65:0] if_to_ib_bus;
  logic [63:0] inst_sram_rdata;
  logic [1:0]  id_pop;
  logic        inst0_valid, inst1_valid;
  logic [31:0] inst0_pc, inst1_pc, inst0, inst1;
  logic        stallreq_ib;

  int n_checks;
  int n_errors;

  // Scoreboard: expected buffer contents, oldest first, {pc, inst}.
  logic [63:0] exp_q[$];
  logic        pend_v;
  logic [31:0] pend_tgt, pend_base, last_base;

  inst_buffer #(.DEPTH(16), .PTR_W(4)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush           (flush),
    .if_to_ib_bus    (if_to_ib_bus),
    .inst_sram_rdata (inst_sram_rdata),
    .id_pop          (id_pop),
    .inst0_valid     (inst0_valid),
    .inst1_valid     (inst1_valid),
    .inst0_pc        (inst0_pc),
    .inst1_pc        (inst1_pc),
    .inst0           (inst0),
    .inst1           (inst1),
    .stallreq_ib     (stallreq_ib)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory contents seen by the SRAM model.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    case (a)
      32'hbfc00000: return 32'h24010001;
      32'hbfc00004: return 32'h24020002;
      default:      return {a[15:0], ~a[15:0]};
    endcase
  endfunction

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_state();
    logic        e0v, e1v;
    logic [63:0] e0, e1;
    e0v = (exp_q.size() >= 1);
    e1v = (exp_q.size() >= 2);
    e0  = e0v ? exp_q[0] : 64'd0;
    e1  = e1v ? exp_q[1] : 64'd0;
    check_eq("inst0_valid", 64'(inst0_valid), 64'(e0v));
    check_eq("inst1_valid", 64'(inst1_valid), 64'(e1v));
    check_eq("inst0_pc", 64'(inst0_pc), 64'(e0[63:32]));
    check_eq("inst0", 64'(inst0), 64'(e0[31:0]));
    check_eq("inst1_pc", 64'(inst1_pc), 64'(e1[63:32]));
    check_eq("inst1", 64'(inst1), 64'(e1[31:0]));
    check_eq("stallreq_ib", 64'(stallreq_ib), 64'((16 - exp_q.size()) < 4));
  endtask

  // Driver: one clock cycle of IF descriptor, SRAM data, ID pop and flush.
  task automatic cycle(input logic ce, input logic disc, input logic [31:0] tgt,
                       input logic [1:0] pop, input logic fl);
    logic [31:0] base;
    base            = tgt & 32'hffff_fff8;
    if_to_ib_bus    = {disc, ce, tgt, base};
    inst_sram_rdata = {inst_of(last_base + 32'd4), inst_of(last_base)};
    id_pop          = pop;
    flush           = fl;
    if (fl) begin
      exp_q.delete();
      pend_v = 1'b0;
    end else begin
      for (int i = 0; i < int'(pop); i++)
        if (exp_q.size() > 0) void'(exp_q.pop_front());
      if (pend_v) begin
        if (!pend_tgt[2]) exp_q.push_back({pend_base, inst_of(pend_base)});
        exp_q.push_back({pend_base + 32'd4, inst_of(pend_base + 32'd4)});
      end
      pend_v = ce & ~disc;
    end
    pend_tgt  = tgt;
    pend_base = base;
    last_base = base;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input logic ce, input logic [31:0] tgt);
    rst             = 1'b1;
    flush           = 1'b0;
    id_pop          = 2'd0;
    if_to_ib_bus    = {1'b0, ce, tgt, tgt & 32'hffff_fff8};
    inst_sram_rdata = {inst_of(last_base + 32'd4), inst_of(last_base)};
    exp_q.delete();
    pend_v = 1'b0;
    @(posedge clk);
    #1;
    check_state();
    check_eq("rst_inst0_valid", 64'(inst0_valid), 64'd0);
    check_eq("rst_inst1_valid", 64'(inst1_valid), 64'd0);
    check_eq("rst_inst0_pc", 64'(inst0_pc), 64'd0);
    check_eq("rst_inst0", 64'(inst0), 64'd0);
    check_eq("rst_stall", 64'(stallreq_ib), 64'd0);
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] pc;
    n_checks        = 0;
    n_errors        = 0;
    rst             = 1'b1;
    flush           = 1'b0;
    id_pop          = 2'd0;
    if_to_ib_bus    = '0;
    inst_sram_rdata = '0;
    pend_v          = 1'b0;
    pend_tgt        = '0;
    pend_base       = '0;
    last_base       = '0;

    do_reset(1'b0, 32'd0);
    do_reset(1'b0, 32'd0);

    // Sequential fetch, two-cycle latency, no same-cycle bypass
    cycle(1, 0, 32'hbfc00000, 0, 0);
    check_eq("seq_nobypass", 64'(inst0_valid), 64'd0);
    cycle(1, 0, 32'hbfc00008, 0, 0);
    check_eq("seq_pc0", 64'(inst0_pc), 64'hbfc00000);
    check_eq("seq_pc1", 64'(inst1_pc), 64'hbfc00004);
    check_eq("seq_inst0", 64'(inst0), 64'h24010001);
    check_eq("seq_inst1", 64'(inst1), 64'h24020002);
    cycle(0, 0, 32'hbfc00010, 2, 0);
    check_eq("seq2_pc0", 64'(inst0_pc), 64'hbfc00008);
    check_eq("seq2_pc1", 64'(inst1_pc), 64'hbfc0000c);
    cycle(0, 0, 32'd0, 2, 0);
    check_eq("seq_empty", 64'(inst0_valid), 64'd0);

    // Odd-word target: single entry from the upper word
    cycle(1, 0, 32'hbfc00014, 0, 0);
    cycle(0, 0, 32'd0, 0, 0);
    check_eq("una_pc0", 64'(inst0_pc), 64'hbfc00014);
    check_eq("una_inst0", 64'(inst0), 64'h0014ffeb);
    check_eq("una_v1", 64'(inst1_valid), 64'd0);
    cycle(0, 0, 32'd0, 1, 0);

    // Discard kills the same-cycle request; buffered entries stay
    cycle(1, 0, 32'hbfc00020, 0, 0);
    cycle(1, 1, 32'hbfc00028, 0, 0);
    cycle(1, 0, 32'hbfc00100, 0, 0);
    check_eq("disc_hold_pc1", 64'(inst1_pc), 64'hbfc00024);
    cycle(0, 0, 32'd0, 0, 0);
    check_eq("disc_pc0", 64'(inst0_pc), 64'hbfc00020);
    cycle(0, 0, 32'd0, 2, 0);
    check_eq("disc_target_pc0", 64'(inst0_pc), 64'hbfc00100);
    check_eq("disc_target_pc1", 64'(inst1_pc), 64'hbfc00104);
    cycle(0, 0, 32'd0, 2, 0);

    // Fill until stall with no pops: odd start lands exactly on 13
    cycle(1, 0, 32'hbfc01004, 0, 0);
    pc = 32'hbfc01008;
    for (int i = 0; i < 12; i++) begin
      if (!stallreq_ib) begin
        cycle(1, 0, pc, 0, 0);
        pc += 32'd8;
      end else begin
        cycle(0, 0, pc, 0, 0);
      end
    end
    check_eq("fill_stall", 64'(stallreq_ib), 64'd1);
    check_eq("fill_head_pc", 64'(inst0_pc), 64'hbfc01004);
    check_eq("fill_head1_pc", 64'(inst1_pc), 64'hbfc01008);

    // Drain one per cycle while IF keeps fetching: pointers wrap
    for (int i = 0; i < 40; i++) begin
      if (!stallreq_ib && i < 24) begin
        cycle(1, 0, pc, (exp_q.size() > 0) ? 2'd1 : 2'd0, 0);
        pc += 32'd8;
      end else begin
        cycle(0, 0, pc, (exp_q.size() > 0) ? 2'd1 : 2'd0, 0);
      end
    end
    check_eq("drain_empty", 64'(inst0_valid), 64'd0);
    check_eq("drain_stall", 64'(stallreq_ib), 64'd0);

    // Flush with 9 entries and a request in flight
    cycle(1, 0, 32'hbfc02004, 0, 0);
    cycle(1, 0, 32'hbfc02008, 0, 0);
    cycle(1, 0, 32'hbfc02010, 0, 0);
    cycle(1, 0, 32'hbfc02018, 0, 0);
    cycle(1, 0, 32'hbfc02020, 0, 0);
    cycle(1, 0, 32'hbfc02028, 0, 0);
    check_eq("pre_flush_pc0", 64'(inst0_pc), 64'hbfc02004);
    check_eq("pre_flush_pc1", 64'(inst1_pc), 64'hbfc02008);
    cycle(0, 0, 32'd0, 1, 1);
    check_eq("flush_v0", 64'(inst0_valid), 64'd0);
    check_eq("flush_v1", 64'(inst1_valid), 64'd0);
    cycle(1, 0, 32'hbfc03000, 0, 0);
    check_eq("flush_dropped", 64'(inst0_valid), 64'd0);
    cycle(0, 0, 32'd0, 0, 0);
    check_eq("post_flush_pc0", 64'(inst0_pc), 64'hbfc03000);
    check_eq("post_flush_pc1", 64'(inst1_pc), 64'hbfc03004);

    // Push two / pop one at count one
    cycle(1, 0, 32'hbfc04000, 1, 0);
    check_eq("pp_pre_pc0", 64'(inst0_pc), 64'hbfc03004);
    check_eq("pp_pre_v1", 64'(inst1_valid), 64'd0);
    cycle(0, 0, 32'd0, 1, 0);
    check_eq("pp_pc0", 64'(inst0_pc), 64'hbfc04000);
    check_eq("pp_pc1", 64'(inst1_pc), 64'hbfc04004);
    check_eq("pp_v1", 64'(inst1_valid), 64'd1);

    // Reset mid-operation with a request in flight and one presented
    cycle(1, 0, 32'hbfc05000, 0, 0);
    cycle(1, 0, 32'hbfc05008, 0, 0);
    do_reset(1'b1, 32'hbfc06000);
    cycle(0, 0, 32'd0, 0, 0);
    check_eq("rst_dropped", 64'(inst0_valid), 64'd0);
    cycle(1, 0, 32'hbfc07000, 0, 0);
    cycle(0, 0, 32'd0, 0, 0);
    check_eq("post_rst_pc0", 64'(inst0_pc), 64'hbfc07000);
    check_eq("post_rst_inst1", 64'(inst1), 64'(inst_of(32'hbfc07004)));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
